// File: rtl/fs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fs_pkg
// Description : Shared constants and elaboration helpers for the pipelined
//               ripple-borrow subtractor (fs_pipe / fs_seg).
//               - nstage()    : number of SEG-bit pipeline stages
//               - cfg_ok()    : WIDTH/SEG legality test, checked at elaboration
//               - bent_off()  : offset of a stage's subtrahend slice on the
//                               packed inter-stage operand bus
// Revision    : 1.0 - initial release
// ============================================================================
package fs_pkg;

    localparam int c_DEF_WIDTH = 16;
    localparam int c_DEF_SEG   = 4;

    // Number of register stages (and cycles of latency).
    function automatic int nstage(input int width, input int seg);
        return width / seg;
    endfunction

    // The operand must split into a whole number of non-empty segments.
    function automatic bit cfg_ok(input int width, input int seg);
        return (seg > 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

    // Stage k consumes subtrahend segments k..NSTAGE-1, i.e. width - k*seg
    // bits. These slices are packed back to back on one bus, so the slice
    // for stage k starts after the slices of stages 0..k-1.
    function automatic int bent_off(input int k, input int width, input int seg);
        return (k * width) - ((seg * k * (k - 1)) / 2);
    endfunction

endpackage : fs_pkg
`default_nettype wire

// File: rtl/fs_seg.sv
`default_nettype none
// ============================================================================
// Module      : fs_seg
// Description : Combinational SEG-bit ripple-borrow subtractor built from a
//               chain of full subtractors, d = a - b - bin.
// Ports       : a    [SEG-1:0] in  - minuend segment
//               b    [SEG-1:0] in  - subtrahend segment
//               bin            in  - borrow into the LSB
//               d    [SEG-1:0] out - difference segment
//               bout           out - borrow out of the MSB
// Revision    : 1.0 - initial release
// ============================================================================
module fs_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           bin,
    output logic [SEG-1:0] d,
    output logic           bout
);

    // w_c[i] is the borrow into bit i; w_c[SEG] leaves the segment.
    logic [SEG:0] w_c;

    always_comb begin
        w_c    = '0;
        d      = '0;
        w_c[0] = bin;
        for (int i = 0; i < SEG; i++) begin
            d[i]     = a[i] ^ b[i] ^ w_c[i];
            // Borrow when a=0,b=1, or when a==b and a borrow is pending.
            w_c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_c[i]);
        end
    end

    assign bout = w_c[SEG];

endmodule : fs_seg
`default_nettype wire

// File: rtl/fs_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fs_pipe
// Description : Pipelined ripple-borrow subtractor, d = a - b - bin modulo
//               2^WIDTH, with unsigned borrow-out and signed overflow.
//               One SEG-bit segment is resolved per register stage; the
//               borrow travels between stages with the data so the critical
//               path is a single SEG-bit ripple. Valid/ready on both sides,
//               one result per cycle, NSTAGE = WIDTH/SEG cycles latency.
// Ports       : clk                  in  - clock, rising edge
//               rst_n                in  - asynchronous active-low reset
//               in_valid             in  - a, b, bin valid
//               in_ready             out - input accepted this cycle
//               a, b     [WIDTH-1:0] in  - minuend, subtrahend
//               bin                  in  - borrow-in
//               out_valid            out - d, bout, ovf valid
//               out_ready            in  - downstream accepts result
//               d        [WIDTH-1:0] out - difference
//               bout                 out - unsigned borrow-out
//               ovf                  out - signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module fs_pipe
    import fs_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int SEG   = c_DEF_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int NSTAGE = nstage(WIDTH, SEG);
    localparam int BENT_W = bent_off(NSTAGE, WIDTH, SEG);

    if (!cfg_ok(WIDTH, SEG)) begin : g_cfg_err
        $error("fs_pipe: WIDTH must be a positive multiple of SEG");
    end

    // ------------------------------------------------------------------------
    // Stage entry buses: everything stage k needs arrives on index k. Index 0
    // is fed straight from the input port, index k>0 from stage k-1 regs.
    //   w_ent_word : a-side word; segments below k already hold results,
    //                segments k and up still hold the original minuend
    //   w_ent_b    : packed subtrahend segments k..NSTAGE-1 per stage
    //   w_ent_c    : borrow into segment k
    //   w_ent_sgn  : a[MSB] ^ b[MSB], carried along for the overflow term
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]  w_ent_word [NSTAGE];
    logic [BENT_W-1:0] w_ent_b;
    logic [NSTAGE-1:0] w_ent_v;
    logic [NSTAGE-1:0] w_ent_c;
    logic [NSTAGE-1:0] w_ent_sgn;

    logic [NSTAGE-1:0] w_v;
    logic [NSTAGE-1:0] w_rdy;

    logic [WIDTH-1:0]  w_out_word;
    logic              w_out_brw;
    logic              w_out_ovf;

    assign w_ent_word[0]      = a;
    assign w_ent_b[WIDTH-1:0] = b;
    assign w_ent_v[0]         = in_valid;
    assign w_ent_c[0]         = bin;
    assign w_ent_sgn[0]       = a[WIDTH-1] ^ b[WIDTH-1];

    // ------------------------------------------------------------------------
    // Backpressure: a stage may load when it is empty or when the stage after
    // it is loading this cycle. Evaluated from the output end backwards so a
    // full pipe with out_ready high advances every stage together.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rdy             = '0;
        w_rdy[NSTAGE-1]   = ~w_v[NSTAGE-1] | out_ready;
        for (int i = NSTAGE - 2; i >= 0; i--) begin
            w_rdy[i] = ~w_v[i] | w_rdy[i+1];
        end
    end

    assign in_ready = w_rdy[0];

    // ------------------------------------------------------------------------
    // Pipeline stages
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int LO   = k * SEG;
        localparam int BW   = WIDTH - LO;
        localparam int BOFF = bent_off(k, WIDTH, SEG);

        logic [BW-1:0]    w_b_in;
        logic [SEG-1:0]   w_seg_d;
        logic             w_seg_bout;
        logic [WIDTH-1:0] word_d;
        logic [WIDTH-1:0] word_q;
        logic             v_q;
        logic             brw_q;

        // Lowest segment of this slice is segment k of the subtrahend.
        assign w_b_in = w_ent_b[BOFF +: BW];

        fs_seg #(
            .SEG (SEG)
        ) u_seg (
            .a    (w_ent_word[k][LO +: SEG]),
            .b    (w_b_in[SEG-1:0]),
            .bin  (w_ent_c[k]),
            .d    (w_seg_d),
            .bout (w_seg_bout)
        );

        // Overwrite minuend segment k with its difference in place.
        always_comb begin
            word_d            = w_ent_word[k];
            word_d[LO +: SEG] = w_seg_d;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q    <= 1'b0;
                word_q <= '0;
                brw_q  <= 1'b0;
            end else if (w_rdy[k]) begin
                v_q    <= w_ent_v[k];
                word_q <= word_d;
                brw_q  <= w_seg_bout;
            end
        end

        assign w_v[k] = v_q;

        if (k < NSTAGE - 1) begin : g_mid
            logic [BW-SEG-1:0] b_q;
            logic              sgn_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_q   <= '0;
                    sgn_q <= 1'b0;
                end else if (w_rdy[k]) begin
                    b_q   <= w_b_in[BW-1:SEG];
                    sgn_q <= w_ent_sgn[k];
                end
            end

            assign w_ent_word[k+1]                              = word_q;
            assign w_ent_b[bent_off(k + 1, WIDTH, SEG) +: BW-SEG] = b_q;
            assign w_ent_v[k+1]                                 = v_q;
            assign w_ent_c[k+1]                                 = brw_q;
            assign w_ent_sgn[k+1]                               = sgn_q;
        end else begin : g_last
            logic ovf_d;
            logic ovf_q;

            // The top minuend segment is still intact on entry to the last
            // stage, so a[MSB] is read from the entry word here and the
            // overflow is resolved once and registered with the result.
            assign ovf_d = w_ent_sgn[k] & (w_seg_d[SEG-1] ^ w_ent_word[k][WIDTH-1]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (w_rdy[k]) begin
                    ovf_q <= ovf_d;
                end
            end

            assign w_out_word = word_q;
            assign w_out_brw  = brw_q;
            assign w_out_ovf  = ovf_q;
        end
    end

    assign out_valid = w_v[NSTAGE-1];
    assign d         = w_out_word;
    assign bout      = w_out_brw;
    assign ovf       = w_out_ovf;

endmodule : fs_pipe
`default_nettype wire

// File: doc/fs_pipe.md
Name: fs_pipe

Overview:
- Parametrised, pipelined ripple-borrow subtractor computing d = a - b - bin over WIDTH bits, with borrow-out and signed-overflow flags.
- The operand is split into SEG-bit segments, one register stage per segment. The borrow is carried between stages, so the clock period is bounded by one SEG-bit ripple rather than by the full width.
- Valid/ready handshake on both sides, full throughput of one result per cycle. Sits in the datapath alongside the vedic/RCA multiplier blocks, e.g. for the real-part subtraction in the complex multiplier.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of SEG and at least SEG.
- SEG, 4, bits per pipeline segment; NSTAGE = WIDTH/SEG is the number of register stages and the latency.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  a, b, bin valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- a  input  WIDTH  minuend, unsigned or two's complement.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  d, bout, ovf valid.
- out_ready  input  1  downstream accepts the result.
- d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
- bout  output  1  unsigned borrow-out; 1 iff a < b + bin as unsigned values.
- ovf  output  1  signed overflow: (a[MSB] ^ b[MSB]) & (d[MSB] ^ a[MSB]).

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - all stage valid bits and all data, borrow and flag registers clear to 0;
  - out_valid = d = bout = ovf = 0 immediately;
  - in-flight operations are discarded, never emitted after release;
  - in_ready = 1 from the first cycle after release.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage k (0..NSTAGE-1) holds:
  - v[k];
  - result segments 0..k;
  - borrow into segment k+1;
  - unprocessed operand segments k+1..NSTAGE-1 of a and b;
  - a[MSB] ^ b[MSB] (needed for ovf), which rides the pipe.
- Stage 0 computes segment 0 from the inputs a, b and bin. Stage k computes segment k from the stage k-1 registered operands and borrow.
- Per-stage advance: stage_ready[k] = !v[k] | stage_ready[k+1]; stage_ready[NSTAGE-1] = !v[NSTAGE-1] | out_ready; in_ready = stage_ready[0].
  - A stage loads when its ready is 1.
  - Its valid bit takes the upstream valid (in_valid for stage 0). Bubbles collapse.
  - A stage not ready holds all its contents.
- Latency: NSTAGE cycles from input transfer to out_valid, with out_ready held high.
- Ordering: in-order and lossless; no result is duplicated or dropped under any out_ready pattern.
- Capacity: with out_ready held low, exactly NSTAGE operations are accepted, then in_ready = 0. in_ready returns to 1 in the same cycle out_ready rises.
- Outputs d, bout, ovf are registered and stable while out_valid & !out_ready.
- Arithmetic:
  - each segment is a SEG-bit ripple-borrow chain of full subtractors: di = ai ^ bi ^ ci; ci+1 = (~ai & bi) | (~(ai ^ bi) & ci);
  - bout is the borrow out of the MSB segment;
  - wrap-around is modulo 2^WIDTH;
  - ovf is always computed; callers ignore it for unsigned use.
- Boundary cases:
  - simultaneous input and output transfer on a full pipe: the pipe stays full, no stall bubble;
  - NSTAGE = 1 degenerates to a single registered WIDTH-bit subtractor with the same handshake.

Decomposition:
- Package fs_pkg holds:
  - localparam helper function nstage(WIDTH, SEG);
  - elaboration check that WIDTH % SEG == 0.
- Natural sub-module: fs_seg, a combinational SEG-bit ripple-borrow subtractor with ports a, b, bin, d, bout, instantiated once per stage in a generate loop.
- Pipeline registers and handshake logic stay in fs_pipe.

Test Plan (WIDTH=16, SEG=4, latency 4):
- a=0x1234, b=0x0234, bin=0, out_ready=1 -> 4 cycles later out_valid=1, d=0x1000, bout=0, ovf=0.
- a=0x0000, b=0x0000, bin=1 -> d=0xFFFF, bout=1, ovf=0; confirms the borrow ripples through all 4 stages.
- a=0x8000, b=0x0001, bin=0 -> d=0x7FFF, bout=0, ovf=1; also a=0x7FFF, b=0xFFFF -> d=0x8000, bout=1, ovf=1.
- 8 back-to-back random vectors, out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 4; results match the reference model in order; in_ready stays 1 throughout.
- Continuous in_valid with out_ready=0 for 10 cycles -> exactly 4 accepted, then in_ready=0 and outputs held stable. Raise out_ready -> in_ready=1 in the same cycle, no loss or reorder; also random out_ready toggling for 1000 vectors against a scoreboard.
- rst_n pulled low while 3 operations are in flight -> out_valid=0 immediately and d=0. After release, no stale result appears, and a new vector a=5, b=3 -> d=0x0002 after 4 cycles.
